// File: rtl/vga_game_pkg.sv
// Shared definitions for the VGA game datapath: screen geometry, coordinate
// and RGB332 colour types, and a few named colours.
package vga_game_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;
  localparam int COLOR_W  = 8;

  typedef logic [COLOR_W-1:0] rgb332_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam rgb332_t COLOR_BLACK = 8'h00;
  localparam rgb332_t COLOR_WHITE = 8'hFF;

endpackage

// File: rtl/rect_hit_test.sv
// Combinational point-in-rectangle test shared by object renderers.
// Ports:
//   x, y          pixel coordinate under test
//   rx, ry        rectangle top-left corner
//   rw, rh        rectangle width/height (0 means empty)
//   hit           pixel lies inside the rectangle
//   on_edge       pixel lies on the 1-px border (only with CHAR_OUTLINE_EN)
// Build option: CHAR_OUTLINE_EN adds the on_edge output.
module rect_hit_test
  import vga_game_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] rx,
  input  logic [COORD_W-1:0] ry,
  input  logic [COORD_W-1:0] rw,
  input  logic [COORD_W-1:0] rh
`ifdef CHAR_OUTLINE_EN
  ,
  output logic               on_edge
`endif
  ,
  output logic               hit
);

  // One extra bit on every sum so a rectangle reaching past 1023 clips
  // instead of wrapping around to column/row 0.
  logic [COORD_W:0] x_e, y_e, x_lo, y_lo, x_end, y_end;

  assign x_e   = {1'b0, x};
  assign y_e   = {1'b0, y};
  assign x_lo  = {1'b0, rx};
  assign y_lo  = {1'b0, ry};
  assign x_end = {1'b0, rx} + {1'b0, rw};
  assign y_end = {1'b0, ry} + {1'b0, rh};

  assign hit = (x_e >= x_lo) && (x_e < x_end) && (y_e >= y_lo) && (y_e < y_end);

`ifdef CHAR_OUTLINE_EN
  logic [COORD_W:0] x_last, y_last;
  assign x_last  = x_end - 11'd1;
  assign y_last  = y_end - 11'd1;
  assign on_edge = hit && ((x_e == x_lo) || (x_e == x_last) ||
                           (y_e == y_lo) || (y_e == y_last));
`endif

endmodule

// File: rtl/char_pixel_renderer.sv
// Final pixel colour stage for the player character. Latches the character
// rectangle once per frame (tear-free), runs a 2-stage pixel pipeline with
// matching sync delay, and reports the character pixel count of the last
// completed frame.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pix_valid                pixel strobe, pipeline advances only when high
//   frame_start              one-clk pulse at start of vertical blanking
//   pix_x, pix_y             current pixel coordinate
//   video_on_in, hsync_in, vsync_in   raster timing flags
//   char_x/_y/_w/_h, char_color       character rectangle and colour
//   bg_color                 background colour
//   rgb_out                  final RGB332 pixel
//   hsync_out, vsync_out, video_on_out   timing aligned with rgb_out
//   char_hit                 rgb_out pixel belongs to the character
//   hit_count                character pixels drawn in the last frame
// Build option: define CHAR_OUTLINE_EN to draw a 1-px OUTLINE_COLOR border.
module char_pixel_renderer
  import vga_game_pkg::*;
#(
  parameter logic [COLOR_W-1:0] OUTLINE_COLOR = 8'h00,
  parameter int                 COUNT_W       = 16
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               video_on_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [COORD_W-1:0] char_x,
  input  logic [COORD_W-1:0] char_y,
  input  logic [COORD_W-1:0] char_w,
  input  logic [COORD_W-1:0] char_h,
  input  logic [COLOR_W-1:0] char_color,
  input  logic [COLOR_W-1:0] bg_color,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               video_on_out,
  output logic               char_hit,
  output logic [COUNT_W-1:0] hit_count
);

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                 input logic               inc);
    if (inc && !(&v)) return v + 1'b1;
    return v;
  endfunction

  function automatic logic [COLOR_W-1:0] select_color(input logic               vid,
                                                      input logic               hit,
                                                      input logic [COLOR_W-1:0] fg,
                                                      input logic [COLOR_W-1:0] bg);
    if (!vid) return '0;
    if (hit)  return fg;
    return bg;
  endfunction

  logic [COORD_W-1:0] sh_x, sh_y, sh_w, sh_h;
  logic [COLOR_W-1:0] sh_col;

  // Shadow copy of the character: only frame_start may change what is drawn.
  // All-zero after reset means an empty rectangle until the first frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_w   <= '0;
      sh_h   <= '0;
      sh_col <= '0;
    end else if (frame_start) begin
      sh_x   <= char_x;
      sh_y   <= char_y;
      sh_w   <= char_w;
      sh_h   <= char_h;
      sh_col <= char_color;
    end
  end

  logic hit_c;
  logic hit_p1, vid_p1, hs_p1, vs_p1, edge_p1;

`ifdef CHAR_OUTLINE_EN
  logic edge_c;

  rect_hit_test u_hit (
    .x       (pix_x),
    .y       (pix_y),
    .rx      (sh_x),
    .ry      (sh_y),
    .rw      (sh_w),
    .rh      (sh_h),
    .on_edge (edge_c),
    .hit     (hit_c)
  );

  always_ff @(posedge clk) begin
    if (rst)            edge_p1 <= 1'b0;
    else if (pix_valid) edge_p1 <= edge_c;
  end
`else
  rect_hit_test u_hit (
    .x   (pix_x),
    .y   (pix_y),
    .rx  (sh_x),
    .ry  (sh_y),
    .rw  (sh_w),
    .rh  (sh_h),
    .hit (hit_c)
  );

  // Solid fill: the outline select below folds away to the character colour.
  assign edge_p1 = 1'b0;
`endif

  // ---- stage 1: hit test against shadow rectangle, capture timing ----
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_p1 <= 1'b0;
      vid_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else if (pix_valid) begin
      hit_p1 <= hit_c;
      vid_p1 <= video_on_in;
      hs_p1  <= hsync_in;
      vs_p1  <= vsync_in;
    end
  end

  logic [COLOR_W-1:0] fg_p1;
  assign fg_p1 = edge_p1 ? OUTLINE_COLOR : sh_col;

  // ---- stage 2: colour select and aligned timing outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_out      <= '0;
      char_hit     <= 1'b0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      video_on_out <= 1'b0;
    end else if (pix_valid) begin
      rgb_out      <= select_color(vid_p1, hit_p1, fg_p1, bg_color);
      char_hit     <= hit_p1 && vid_p1;
      hsync_out    <= hs_p1;
      vsync_out    <= vs_p1;
      video_on_out <= vid_p1;
    end
  end

  // A hit registered in the same cycle as frame_start belongs to the frame
  // that is ending, so it is folded into hit_count rather than the new count.
  logic               hit_inc;
  logic [COUNT_W-1:0] acc;

  assign hit_inc = pix_valid && hit_p1 && vid_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      hit_count <= '0;
    end else if (frame_start) begin
      hit_count <= sat_inc(acc, hit_inc);
      acc       <= '0;
    end else begin
      acc       <= sat_inc(acc, hit_inc);
    end
  end

endmodule

// File: tb/tb_char_pixel_renderer.sv
// Directed bench for char_pixel_renderer with a frame-level reference model.
// A second instance with an 8-bit counter exercises counter saturation.
module tb_char_pixel_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pix_valid, frame_start, video_on_in, hsync_in, vsync_in;
  logic [9:0] pix_x, pix_y, char_x, char_y, char_w, char_h;
  logic [7:0] char_color, bg_color;

  logic [7:0]  rgb_out, rgb8;
  logic        hsync_out, vsync_out, video_on_out, char_hit;
  logic        hs8, vs8, von8, hit8;
  logic [15:0] hit_count;
  logic [7:0]  hc8;

  char_pixel_renderer dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y), .video_on_in(video_on_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .char_x(char_x), .char_y(char_y), .char_w(char_w), .char_h(char_h),
    .char_color(char_color), .bg_color(bg_color),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .video_on_out(video_on_out), .char_hit(char_hit), .hit_count(hit_count)
  );

  char_pixel_renderer #(.COUNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y), .video_on_in(video_on_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .char_x(char_x), .char_y(char_y), .char_w(char_w), .char_h(char_h),
    .char_color(char_color), .bg_color(bg_color),
    .rgb_out(rgb8), .hsync_out(hs8), .vsync_out(vs8),
    .video_on_out(von8), .char_hit(hit8), .hit_count(hc8)
  );

`ifdef CHAR_OUTLINE_EN
  localparam bit OUTLINE = 1'b1;
`else
  localparam bit OUTLINE = 1'b0;
`endif
  localparam logic [7:0] OUTLINE_COLOR = 8'h00;

  // Reference model: shadow rectangle, one pending pixel (sampled but not yet
  // visible), and an unbounded pixel tally clamped only when reported.
  typedef struct packed {
    logic hit;
    logic edg;
    logic von;
    logic hs;
    logic vs;
  } rec_t;

  int         m_sx, m_sy, m_sw, m_sh;
  logic [7:0] m_col;
  rec_t       pend;
  int         acc, m_hc;
  logic [7:0] e_rgb;
  logic       e_hit, e_hs, e_vs, e_von;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic rec_t model_pix(int x, int y, logic von, logic hs, logic vs);
    rec_t r;
    r.hit = (x >= m_sx) && (x < m_sx + m_sw) && (y >= m_sy) && (y < m_sy + m_sh);
    r.edg = r.hit && (x == m_sx || x == m_sx + m_sw - 1 || y == m_sy || y == m_sy + m_sh - 1);
    r.von = von;
    r.hs  = hs;
    r.vs  = vs;
    return r;
  endfunction

  function automatic int clamp(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic step(input logic pv, input logic fs, input int x, input int y,
                      input logic von, input logic hs, input logic vs);
    rec_t o;
    pix_valid   = pv;
    frame_start = fs;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    video_on_in = von;
    hsync_in    = hs;
    vsync_in    = vs;
    @(posedge clk);
    if (rst) begin
      m_sx = 0; m_sy = 0; m_sw = 0; m_sh = 0; m_col = '0;
      pend = '0; acc = 0; m_hc = 0;
      e_rgb = '0; e_hit = 0; e_hs = 0; e_vs = 0; e_von = 0;
    end else begin
      if (pv) begin
        o     = pend;
        e_von = o.von;
        e_hs  = o.hs;
        e_vs  = o.vs;
        e_hit = o.hit && o.von;
        if (!o.von)                e_rgb = 8'h00;
        else if (!o.hit)           e_rgb = bg_color;
        else if (OUTLINE && o.edg) e_rgb = OUTLINE_COLOR;
        else                       e_rgb = m_col;
        if (e_hit) acc++;
        pend = model_pix(x, y, von, hs, vs);
      end
      if (fs) begin
        m_hc  = acc;
        acc   = 0;
        m_sx  = int'(char_x);
        m_sy  = int'(char_y);
        m_sw  = int'(char_w);
        m_sh  = int'(char_h);
        m_col = char_color;
      end
    end
    #1;
    chk("rgb_out", rgb_out, e_rgb);
    chk("char_hit", char_hit, e_hit);
    chk("hsync_out", hsync_out, e_hs);
    chk("vsync_out", vsync_out, e_vs);
    chk("video_on_out", video_on_out, e_von);
    chk("hit_count", hit_count, clamp(m_hc, 65535));
    chk("rgb_out_c8", rgb8, e_rgb);
    chk("char_hit_c8", hit8, e_hit);
    chk("syncs_c8", {hs8, vs8, von8}, {e_hs, e_vs, e_von});
    chk("hit_count_c8", hc8, clamp(m_hc, 255));
  endtask

  task automatic idle_fs();
    step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        step(1'b1, 1'b0, x, y, (x < 640) && (y < 480),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic set_char(input int x, input int y, input int w, input int h, input logic [7:0] c);
    char_x = 10'(x); char_y = 10'(y); char_w = 10'(w); char_h = 10'(h); char_color = c;
  endtask

  logic [7:0] corner_exp;
  logic       hs320;

  initial begin
    rst = 1'b1;
    pix_valid = 0; frame_start = 0; pix_x = 0; pix_y = 0;
    video_on_in = 0; hsync_in = 0; vsync_in = 0;
    set_char(0, 0, 0, 0, 8'h00);
    bg_color = 8'h00;
    corner_exp = OUTLINE ? OUTLINE_COLOR : 8'hFE;

    // Reset state
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    chk("reset_outputs", {rgb_out, char_hit, hsync_out, vsync_out, video_on_out}, 0);
    chk("reset_hit_count", hit_count, 0);
    rst = 1'b0;

    // Static player over the neighbourhood of the rectangle
    set_char(304, 380, 32, 60, 8'hFE);
    idle_fs();
    scan(298, 341, 375, 444);
    idle_fs();
    chk("static_hit_count", hit_count, 1920);
    chk("saturated_hit_count_c8", hc8, 8'hFF);

    // Directed pixels, bg made distinct from black
    bg_color = 8'h25;
    step(1'b1, 1'b0, 304, 380, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 336, 380, 1'b1, 1'b0, 1'b0);
    chk("px_304_380", rgb_out, corner_exp);
    chk("px_304_380_hit", char_hit, 1);
    step(1'b1, 1'b0, 303, 380, 1'b1, 1'b0, 1'b0);
    chk("px_336_380_bg", rgb_out, 8'h25);
    step(1'b1, 1'b0, 335, 439, 1'b1, 1'b0, 1'b0);
    chk("px_303_380_bg", rgb_out, 8'h25);
    step(1'b1, 1'b0, 310, 400, 1'b1, 1'b0, 1'b0);
    chk("px_335_439", rgb_out, corner_exp);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("px_310_400_interior", rgb_out, 8'hFE);

    // Latency and gating: strobe every other clock, video off at x=320
    hs320 = 1'b0;
    for (int x = 300; x <= 340; x++) begin
      logic h;
      h = 1'($urandom_range(0, 1));
      if (x == 320) hs320 = h;
      step(1'b1, 1'b0, x, 400, x != 320, h, 1'($urandom_range(0, 1)));
      if (x == 321) begin
        chk("gated_rgb", rgb_out, 8'h00);
        chk("gated_hit", char_hit, 0);
        chk("gated_von", video_on_out, 0);
        chk("gated_hsync_delay", hsync_out, hs320);
      end
      step(1'b0, 1'b0, 1023 - x, 7, 1'b1, ~h, 1'b1);
    end

    // Mid-frame property change is invisible until frame_start
    set_char(304, 90, 32, 20, 8'h1C);
    idle_fs();
    scan(0, 340, 95, 99);
    char_x = 10'd0;
    scan(0, 340, 100, 104);
    idle_fs();
    chk("midframe_hit_count", hit_count, 320);
    step(1'b1, 1'b0, 0, 95, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 40, 95, 1'b1, 1'b0, 1'b0);
    chk("newframe_x0_hit", char_hit, 1);
    chk("newframe_x0_rgb", rgb_out, OUTLINE ? OUTLINE_COLOR : 8'h1C);
    scan(0, 40, 96, 97);

    // Right-edge clipping by the active area
    set_char(620, 10, 32, 5, 8'hE3);
    idle_fs();
    scan(600, 659, 8, 16);
    idle_fs();
    chk("clip_hit_count", hit_count, 100);

    // Rectangle past 1023 must not wrap to the left
    set_char(1000, 10, 40, 3, 8'hE0);
    idle_fs();
    step(1'b1, 1'b0, 1010, 11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5, 11, 1'b1, 1'b0, 1'b0);
    chk("nowrap_inside_hit", char_hit, 1);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("nowrap_x5_miss", char_hit, 0);
    chk("nowrap_x5_bg", rgb_out, 8'h25);

    // Zero width draws nothing
    set_char(304, 380, 0, 60, 8'hFE);
    idle_fs();
    scan(300, 340, 378, 382);
    idle_fs();
    chk("zero_width_hit_count", hit_count, 0);

    // frame_start coinciding with a stage-2 hit
    set_char(304, 380, 32, 60, 8'hFE);
    idle_fs();
    step(1'b1, 1'b0, 304, 380, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 305, 380, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 306, 380, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("coincident_hit_count", hit_count, 3);
    chk("coincident_char_hit", char_hit, 1);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle_fs();
    chk("acc_restarted", hit_count, 0);

    // Reset mid-frame: nothing drawn until the next frame_start
    idle_fs();
    scan(298, 341, 378, 381);
    rst = 1'b1;
    step(1'b1, 1'b0, 310, 390, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    chk("midreset_outputs", {rgb_out, char_hit, hsync_out, vsync_out, video_on_out}, 0);
    chk("midreset_hit_count", hit_count, 0);
    scan(298, 341, 382, 385);
    step(1'b1, 1'b0, 310, 390, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 311, 390, 1'b1, 1'b0, 1'b0);
    chk("postreset_no_hit", char_hit, 0);
    chk("postreset_bg", rgb_out, 8'h25);
    idle_fs();
    chk("postreset_hit_count", hit_count, 0);
    step(1'b1, 1'b0, 310, 390, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("redraw_after_fs", char_hit, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
